// File: rtl/data_ram_pipe.sv
`default_nettype none
//==============================================================================
// Module   : data_ram_pipe
// Purpose  : Single-port, byte-lane data memory with a request handshake,
//            registered one-cycle read, out-of-range error reporting and a
//            post-reset hardware clear sequencer.
//
// Ports    : clk       - clock, all state on rising edge
//            rst       - synchronous active-high reset
//            ce        - request valid
//            we        - 1 = write, 0 = read (qualified by ce)
//            addr      - byte address
//            sel       - byte-lane write enables (bit i -> data_i[8i+7:8i])
//            data_i    - write data
//            ready     - request accepted when ce & ready
//            data_o    - registered read data
//            rvalid    - pulse: data_o holds result of previous accepted read
//            err       - pulse: previous accepted request was out of range
//            init_done - high once the clear sequence has completed
//
// Revision : 1.0 - initial release
//==============================================================================
module data_ram_pipe #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 32,
    parameter int DEPTH_LOG2     = 10,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ce,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W/8-1:0]   sel,
    input  logic [DATA_W-1:0]     data_i,
    output logic                  ready,
    output logic [DATA_W-1:0]     data_o,
    output logic                  rvalid,
    output logic                  err,
    output logic                  init_done
);

    localparam int NB    = DATA_W / 8;
    localparam int LSB   = (NB > 1) ? $clog2(NB) : 0;
    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;
    localparam logic [0:0] ST_RESET = CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;

    localparam logic [DEPTH_LOG2-1:0] CLR_LAST = {DEPTH_LOG2{1'b1}};

    logic [DATA_W-1:0]     mem_q [0:DEPTH-1];

    logic [0:0]            state_q,  state_d;
    logic [DEPTH_LOG2-1:0] clr_idx_q, clr_idx_d;
    logic [DATA_W-1:0]     data_o_q, data_o_d;
    logic                  rvalid_q, rvalid_d;
    logic                  err_q,    err_d;

    logic [DEPTH_LOG2-1:0] w_idx;
    logic                  w_oor;
    logic                  w_acc;
    logic                  w_clr_we;
    logic                  w_unused;

    // Low byte-offset bits never take part in indexing; this reduction
    // keeps them formally consumed.
    assign w_unused = ^addr;

    assign w_idx = addr[DEPTH_LOG2+LSB-1:LSB];

    // Any address bit above the array span flags the request out of range.
    generate
        if (DEPTH_LOG2 + LSB < ADDR_W) begin : g_oor
            assign w_oor = |addr[ADDR_W-1:DEPTH_LOG2+LSB];
        end else begin : g_no_oor
            assign w_oor = 1'b0;
        end
    endgenerate

    assign ready     = (state_q == ST_RUN);
    assign init_done = (state_q == ST_RUN);

    // A request sampled while rst is high is never acted upon.
    assign w_acc    = ce & ready & ~rst;
    assign w_clr_we = (state_q == ST_CLEAR) & ~rst;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        data_o_d  = data_o_q;
        rvalid_d  = 1'b0;
        err_d     = 1'b0;

        if (state_q == ST_CLEAR) begin
            // Index wraps to zero naturally after the last word.
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == CLR_LAST) begin
                state_d = ST_RUN;
            end
        end

        if (w_acc) begin
            if (w_oor) begin
                err_d = 1'b1;
                if (!we) begin
                    data_o_d = '0;
                    rvalid_d = 1'b1;
                end
            end else if (!we) begin
                data_o_d = mem_q[w_idx];
                rvalid_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_RESET;
            clr_idx_q <= '0;
            data_o_q  <= '0;
            rvalid_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            data_o_q  <= data_o_d;
            rvalid_q  <= rvalid_d;
            err_q     <= err_d;
        end
    end

    // Array storage carries no reset; only the clear sequencer zeroes it.
    always_ff @(posedge clk) begin
        if (w_clr_we) begin
            mem_q[clr_idx_q] <= '0;
        end else if (w_acc && we && !w_oor) begin
            for (int i = 0; i < NB; i++) begin
                if (sel[i]) begin
                    mem_q[w_idx][8*i +: 8] <= data_i[8*i +: 8];
                end
            end
        end
    end

    assign data_o = data_o_q;
    assign rvalid = rvalid_q;
    assign err    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_ram_pipe.sv
`default_nettype none
//==============================================================================
// Module   : tb_data_ram_pipe
// Purpose  : Self-checking scoreboard bench for data_ram_pipe
//            (DATA_W=32, ADDR_W=32, DEPTH_LOG2=4, CLEAR_ON_RESET=1).
// Revision : 1.0 - initial release
//==============================================================================
module tb_data_ram_pipe;

    localparam int DW    = 32;
    localparam int AW    = 32;
    localparam int DL2   = 4;
    localparam int NB    = 4;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          ce;
    logic          we;
    logic [AW-1:0] addr;
    logic [NB-1:0] sel;
    logic [DW-1:0] din;
    logic          ready;
    logic [DW-1:0] dout;
    logic          rvalid;
    logic          err;
    logic          init_done;

    always #5 clk = ~clk;

    data_ram_pipe #(
        .DATA_W         (DW),
        .ADDR_W         (AW),
        .DEPTH_LOG2     (DL2),
        .CLEAR_ON_RESET (1'b1)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .we        (we),
        .addr      (addr),
        .sel       (sel),
        .data_i    (din),
        .ready     (ready),
        .data_o    (dout),
        .rvalid    (rvalid),
        .err       (err),
        .init_done (init_done)
    );

    typedef struct {
        int          due;
        bit          rv;
        bit          er;
        logic [31:0] data;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [DEPTH];
    logic [31:0] exp_dout;
    int          cyc      = 0;
    int          checks   = 0;
    int          failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Compares the outputs of the cycle just completed against the scoreboard.
    task automatic monitor();
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check_eq("rvalid", {31'b0, rvalid}, {31'b0, e.rv});
            check_eq("err",    {31'b0, err},    {31'b0, e.er});
            if (e.rv) begin
                exp_dout = e.data;
            end
        end else begin
            check_eq("idle_rvalid", {31'b0, rvalid}, 32'd0);
            check_eq("idle_err",    {31'b0, err},    32'd0);
        end
        check_eq("data_o", dout, exp_dout);
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        monitor();
    endtask

    task automatic idle(input int n);
        ce = 1'b0;
        repeat (n) tick();
    endtask

    task automatic req(input bit w, input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        exp_t        e;
        logic [3:0]  idx;
        bit          oor;
        check_eq("ready_req", {31'b0, ready}, 32'd1);
        ce   = 1'b1;
        we   = w;
        addr = a;
        sel  = s;
        din  = d;
        idx  = a[5:2];
        oor  = |a[31:6];
        e.due  = cyc + 1;
        e.er   = oor;
        e.rv   = !w;
        e.data = '0;
        if (!oor) begin
            if (w) begin
                for (int i = 0; i < NB; i++) begin
                    if (s[i]) model[idx][8*i +: 8] = d[8*i +: 8];
                end
            end else begin
                e.data = model[idx];
            end
        end
        sb.push_back(e);
        tick();
        ce = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ce  = 1'b0;
        sb.delete();
        exp_dout = '0;
        tick();
        tick();
        check_eq("rst_ready",     {31'b0, ready},     32'd0);
        check_eq("rst_init_done", {31'b0, init_done}, 32'd0);
    endtask

    // Releases reset and follows the clear sequence; optionally drives
    // junk writes that must be ignored while not ready.
    task automatic wait_clear(input bit junk);
        rst = 1'b0;
        check_eq("clr_ready_0", {31'b0, ready}, 32'd0);
        for (int k = 1; k <= DEPTH; k++) begin
            if (junk && k < DEPTH) begin
                ce = 1'b1; we = 1'b1; addr = 32'h0; sel = 4'hF; din = 32'hDEAD_BEEF;
            end else begin
                ce = 1'b0;
            end
            tick();
            check_eq("clr_ready",     {31'b0, ready},     (k == DEPTH) ? 32'd1 : 32'd0);
            check_eq("clr_init_done", {31'b0, init_done}, (k == DEPTH) ? 32'd1 : 32'd0);
        end
        ce = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b0; we = 1'b0; addr = '0; sel = '0; din = '0;
        exp_dout = '0;

        // Clear with ignored writes during CLEAR, then read every word.
        do_reset();
        wait_clear(1'b1);
        for (int i = 0; i < DEPTH; i++) req(1'b0, 32'(i * 4), 4'h0, 32'h0);
        idle(1);

        // Byte lanes.
        req(1'b1, 32'h8, 4'hF,    32'hAABB_CCDD);
        req(1'b1, 32'h8, 4'b0101, 32'h1122_3344);
        req(1'b0, 32'h8, 4'h0,    32'h0);
        idle(2);
        // Low address bits are ignored for indexing.
        req(1'b0, 32'h9, 4'h0, 32'h0);
        idle(1);

        // Back-to-back writes then reads.
        req(1'b1, 32'h0, 4'hF, 32'h0102_0304);
        req(1'b1, 32'h4, 4'hF, 32'h1020_3040);
        req(1'b1, 32'h8, 4'hF, 32'h5566_7788);
        req(1'b1, 32'hC, 4'hF, 32'h99AA_BBCC);
        req(1'b0, 32'h0, 4'h0, 32'h0);
        req(1'b0, 32'h4, 4'h0, 32'h0);
        req(1'b0, 32'h8, 4'h0, 32'h0);
        req(1'b0, 32'hC, 4'h0, 32'h0);
        req(1'b1, 32'h4, 4'hF, 32'h0000_0055);
        req(1'b0, 32'h4, 4'h0, 32'h0);
        // sel=0 write is a no-op.
        req(1'b1, 32'hC, 4'h0, 32'hFFFF_FFFF);
        req(1'b0, 32'hC, 4'h0, 32'h0);
        idle(2);

        // Out of range.
        req(1'b1, 32'h0,        4'hF, 32'h1234_5678);
        req(1'b1, 32'h40,       4'hF, 32'hCAFE_F00D);
        req(1'b0, 32'h0,        4'h0, 32'h0);
        req(1'b0, 32'h40,       4'h0, 32'h0);
        req(1'b0, 32'h8000_0000, 4'h0, 32'h0);
        req(1'b0, 32'h4,        4'h0, 32'h0);
        idle(3);

        // Reset in RUN right after a read: pending output dropped, array cleared.
        req(1'b0, 32'h8, 4'h0, 32'h0);
        do_reset();
        wait_clear(1'b0);
        req(1'b0, 32'h8, 4'h0, 32'h0);
        idle(1);

        // Reset mid-clear restarts a full clear.
        req(1'b1, 32'h14, 4'hF, 32'h7777_7777);
        idle(1);
        do_reset();
        rst = 1'b0;
        repeat (7) tick();
        do_reset();
        wait_clear(1'b0);
        req(1'b0, 32'h14, 4'h0, 32'h0);
        req(1'b0, 32'h0,  4'h0, 32'h0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/data_ram_pipe.md
# data_ram_pipe

Parametrised, single-port, byte-lane data memory for the MEM stage and the simulation top. It adds a request handshake, a registered one-cycle read, out-of-range error reporting and a post-reset hardware clear sequencer. It has the same address/byte-select semantics as the current data memory, generalised in data width and depth.

## Interface
Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8; NB = DATA_W/8 byte lanes, LSB = log2(NB)
- ADDR_W, 32, byte address width
- DEPTH_LOG2, 10, log2 of word count; DEPTH = 2^DEPTH_LOG2 words; DEPTH_LOG2+LSB ≤ ADDR_W
- CLEAR_ON_RESET, 1, 1 = zero whole array after reset; 0 = skip clear

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- ce  in  1  request valid
- we  in  1  1 = write, 0 = read (qualified by ce)
- addr  in  ADDR_W  byte address
- sel  in  NB  byte-lane enables for writes; bit i covers data_i[8i+7:8i]
- data_i  in  DATA_W  write data
- ready  out  1  request accepted this cycle when ce & ready
- data_o  out  DATA_W  read data
- rvalid  out  1  one-cycle pulse: data_o holds the result of the previous accepted read
- err  out  1  one-cycle pulse: previous accepted request was out of range
- init_done  out  1  high once the clear sequence is complete

## Operation
- Word index = addr[DEPTH_LOG2+LSB-1:LSB]. Low LSB address bits are ignored for indexing.
- Out of range: any bit of addr[ADDR_W-1:DEPTH_LOG2+LSB] is set.
- FSM states: CLEAR, RUN.
  - rst → CLEAR if CLEAR_ON_RESET=1, else RUN. clr_idx is reset to 0.
  - CLEAR: writes all-zero word at clr_idx, all lanes, one word per cycle; clr_idx increments. ready=0 and init_done=0. Requests are ignored, not queued.
  - CLEAR → RUN on the cycle clr_idx = DEPTH-1 is written. clr_idx wraps to 0. init_done=1 from the next cycle.
  - RUN: ready=1 and init_done=1 every cycle.
- Accepted write, in range: lanes with sel[i]=1 are updated at that edge; other lanes keep their value. sel=0 is a legal no-op. No rvalid.
- Accepted read, in range: full word is registered into data_o; rvalid=1 next cycle.
- Accepted request, out of range: no memory change. err=1 next cycle. For a read: data_o ← 0 and rvalid=1 with err.
- data_o holds its last value until the next accepted read.
- Single port: one request per cycle. Read of a word written in the previous cycle returns the new data.

## Timing
- Reset values: ready=0 (1 if CLEAR_ON_RESET=0), data_o=0, rvalid=0, err=0, init_done=0 (1 if CLEAR_ON_RESET=0).
- Clear duration: exactly DEPTH cycles after rst deasserts. First accepted request is at cycle DEPTH+1 relative to the first non-reset edge.
- Read latency: 1 cycle (request at edge N, data_o/rvalid valid after edge N+1). Back-to-back reads are sustained every cycle.
- Write takes effect at the accepting edge. Throughput is 1 request/cycle in RUN.
- rst asserted mid-CLEAR restarts the clear from index 0. rst in RUN drops any pending rvalid/err and re-enters CLEAR. Array contents are not reset except by the clear sequence.
- ce while ready=0 has no effect and produces no err/rvalid.

## Test plan
- Clear: CLEAR_ON_RESET=1, DEPTH_LOG2=4. Release rst → ready=0 for 16 cycles, then ready=1 and init_done=1. Reads of words 0..15 → 0x00000000 each with rvalid.
- Byte lanes: write 0xAABBCCDD sel=1111 to addr 0x8, then 0x11223344 sel=0101. Read 0x8 → 0xAA22CC44 one cycle later.
- Back-to-back: writes to 0x0..0xC, then reads every cycle → four consecutive rvalid pulses with correct data. Write 0x55 at 0x4 then read 0x4 next cycle → 0x55.
- Out of range: DEPTH_LOG2=4. Write 0x40 → err=1, word 0 unchanged. Read 0x40 → rvalid=1, err=1, data_o=0.
- Reset mid-clear: assert rst at clear cycle 7 → ready stays 0 for a full 16 cycles after the new release.
- Ignored requests: ce=1 with we=1 during CLEAR → no write (post-clear read returns 0), no err.
